// File: rtl/umi_sim_pkg.sv
// Shared definitions for the UMI simulation-side packet plumbing.
// Pointer helpers take zero-extended pointers so any sim FIFO can reuse them.
package umi_sim_pkg;

  localparam int UMI_UW = 256;

  typedef logic [UMI_UW-1:0] umi_packet_t;

  // Pointers carry one wrap bit above the index bits (width aw+1).
  function automatic logic ptr_is_full(input logic [31:0] wr, input logic [31:0] rd, input int aw);
    logic [31:0] mask;
    mask = (32'd1 << (aw + 1)) - 32'd1;
    return ((wr ^ rd) & mask) == (32'd1 << aw);
  endfunction

  function automatic logic ptr_is_empty(input logic [31:0] wr, input logic [31:0] rd, input int aw);
    logic [31:0] mask;
    mask = (32'd1 << (aw + 1)) - 32'd1;
    return ((wr ^ rd) & mask) == 32'd0;
  endfunction

endpackage

// File: rtl/umi_pkt_fifo_mem.sv
// Packet storage: DEPTH x UW register array, one write port, asynchronous read.
// Contents are deliberately not reset; validity is tracked by the pointers.
module umi_pkt_fifo_mem #(
  parameter int UW    = 256,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [UW-1:0] wr_data_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [UW-1:0] rd_data_o
);

  logic [UW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/umi_pkt_fifo.sv
// Elastic first-word-fall-through UMI packet buffer with occupancy count and
// a clearable high-water mark. Ready depends only on registered state and rst.
module umi_pkt_fifo
  import umi_sim_pkg::*;
#(
  parameter int UW    = UMI_UW,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          umi_in_valid,
  input  logic [UW-1:0] umi_in_packet,
  output logic          umi_in_ready,
  output logic          umi_out_valid,
  output logic [UW-1:0] umi_out_packet,
  input  logic          umi_out_ready,
  output logic [AW:0]   count,
  output logic [AW:0]   hwm,
  input  logic          hwm_clear
);

  localparam logic [AW:0] ONE = (AW+1)'(1);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;
  logic [AW:0] hwm_q, hwm_d;
  logic        full, empty, push, pop;

  assign full  = ptr_is_full(32'(wr_ptr_q), 32'(rd_ptr_q), AW);
  assign empty = ptr_is_empty(32'(wr_ptr_q), 32'(rd_ptr_q), AW);

  // A full FIFO refuses input even if the head is popped this same cycle.
  assign umi_in_ready  = !full && !rst;
  assign umi_out_valid = !empty;
  assign push          = umi_in_valid && umi_in_ready;
  assign pop           = umi_out_valid && umi_out_ready;

  umi_pkt_fifo_mem #(
    .UW    (UW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk       (clk),
    .wr_en_i   (push),
    .wr_addr_i (wr_ptr_q[AW-1:0]),
    .wr_data_i (umi_in_packet),
    .rd_addr_i (rd_ptr_q[AW-1:0]),
    .rd_data_o (umi_out_packet)
  );

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    hwm_d    = hwm_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + ONE;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + ONE;
      2'b01:   count_d = count_q - ONE;
      default: count_d = count_q;
    endcase
    // A clear restarts tracking from the post-update occupancy, not from zero.
    if (hwm_clear) begin
      hwm_d = count_d;
    end else if (count_d > hwm_q) begin
      hwm_d = count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      hwm_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      hwm_q    <= hwm_d;
    end
  end

  assign count = count_q;
  assign hwm   = hwm_q;

endmodule

// File: tb/tb_umi_pkt_fifo.sv
// Bench for umi_pkt_fifo: table-driven vectors plus queue-based scoreboard
// sequences for fill/backpressure, streaming, random traffic and reset.
module tb_umi_pkt_fifo;
  import umi_sim_pkg::*;

  localparam int UW    = UMI_UW;
  localparam int DEPTH = 4;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          umi_in_valid = 1'b0;
  logic [UW-1:0] umi_in_packet = '0;
  logic          umi_in_ready;
  logic          umi_out_valid;
  logic [UW-1:0] umi_out_packet;
  logic          umi_out_ready = 1'b0;
  logic [AW:0]   count;
  logic [AW:0]   hwm;
  logic          hwm_clear = 1'b0;

  umi_pkt_fifo #(.UW(UW), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .umi_in_valid   (umi_in_valid),
    .umi_in_packet  (umi_in_packet),
    .umi_in_ready   (umi_in_ready),
    .umi_out_valid  (umi_out_valid),
    .umi_out_packet (umi_out_packet),
    .umi_out_ready  (umi_out_ready),
    .count          (count),
    .hwm            (hwm),
    .hwm_clear      (hwm_clear)
  );

  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model: queue of packets held in the FIFO plus expected hwm.
  logic [UW-1:0] sb[$];
  int            m_hwm = 0;
  bit            known = 1'b0;
  int            pops  = 0;
  logic [UW-1:0] last_pop;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       r;
    logic       c;
    int         cnt;
    int         hw;
    logic       val;
    logic [7:0] pkt;
  } vec_t;

  vec_t vecs[18];

  function automatic vec_t mk(logic v, logic [7:0] d, logic r, logic c,
                              int cnt, int hw, logic val, logic [7:0] pkt);
    vec_t t;
    t.v = v; t.d = d; t.r = r; t.c = c;
    t.cnt = cnt; t.hw = hw; t.val = val; t.pkt = pkt;
    return t;
  endfunction

  task automatic chk(input string name, input logic [UW-1:0] act, input logic [UW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: drive, check pre-edge handshake outputs, clock, update model,
  // check registered count/hwm.
  task automatic cycle(input logic v, input logic [UW-1:0] d, input logic r,
                       input logic c, input logic rs);
    logic exp_ready, exp_valid, do_push, do_pop;
    umi_in_valid  = v;
    umi_in_packet = d;
    umi_out_ready = r;
    hwm_clear     = c;
    rst           = rs;
    #1;
    exp_ready = !rs && (sb.size() < DEPTH);
    exp_valid = sb.size() > 0;
    if (known) begin
      chk("in_ready", UW'(umi_in_ready), UW'(exp_ready));
      chk("out_valid", UW'(umi_out_valid), UW'(exp_valid));
      if (exp_valid) chk("out_packet", umi_out_packet, sb[0]);
    end
    do_push = v && exp_ready;
    do_pop  = r && exp_valid;
    @(posedge clk);
    #1;
    if (rs) begin
      sb.delete();
      m_hwm = 0;
      known = 1'b1;
    end else begin
      if (do_pop) begin
        last_pop = sb.pop_front();
        pops++;
      end
      if (do_push) sb.push_back(d);
      if (c || sb.size() > m_hwm) m_hwm = sb.size();
    end
    if (known) begin
      chk("count", UW'(count), UW'(sb.size()));
      chk("hwm", UW'(hwm), UW'(m_hwm));
    end
  endtask

  initial begin
    int sent;
    int guard;
    logic [UW-1:0] payload;

    // Basic push/hold/drain, then hwm clear behaviour; expectations are post-edge.
    vecs[0]  = mk(1'b1, 8'hA1, 1'b0, 1'b0, 1, 1, 1'b1, 8'hA1);
    vecs[1]  = mk(1'b1, 8'hA2, 1'b0, 1'b0, 2, 2, 1'b1, 8'hA1);
    vecs[2]  = mk(1'b1, 8'hA3, 1'b0, 1'b0, 3, 3, 1'b1, 8'hA1);
    vecs[3]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 3, 3, 1'b1, 8'hA1);
    vecs[4]  = mk(1'b0, 8'h00, 1'b1, 1'b0, 2, 3, 1'b1, 8'hA2);
    vecs[5]  = mk(1'b0, 8'h00, 1'b1, 1'b0, 1, 3, 1'b1, 8'hA3);
    vecs[6]  = mk(1'b0, 8'h00, 1'b1, 1'b0, 0, 3, 1'b0, 8'h00);
    vecs[7]  = mk(1'b1, 8'hB1, 1'b0, 1'b0, 1, 3, 1'b1, 8'hB1);
    vecs[8]  = mk(1'b1, 8'hB2, 1'b0, 1'b0, 2, 3, 1'b1, 8'hB1);
    vecs[9]  = mk(1'b1, 8'hB3, 1'b0, 1'b0, 3, 3, 1'b1, 8'hB1);
    vecs[10] = mk(1'b1, 8'hB4, 1'b0, 1'b0, 4, 4, 1'b1, 8'hB1);
    vecs[11] = mk(1'b0, 8'h00, 1'b1, 1'b0, 3, 4, 1'b1, 8'hB2);
    vecs[12] = mk(1'b0, 8'h00, 1'b1, 1'b0, 2, 4, 1'b1, 8'hB3);
    vecs[13] = mk(1'b0, 8'h00, 1'b1, 1'b0, 1, 4, 1'b1, 8'hB4);
    vecs[14] = mk(1'b0, 8'h00, 1'b0, 1'b1, 1, 1, 1'b1, 8'hB4);
    vecs[15] = mk(1'b1, 8'hC1, 1'b0, 1'b1, 2, 2, 1'b1, 8'hB4);
    vecs[16] = mk(1'b0, 8'h00, 1'b1, 1'b0, 1, 2, 1'b1, 8'hC1);
    vecs[17] = mk(1'b0, 8'h00, 1'b1, 1'b0, 0, 2, 1'b0, 8'h00);

    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("reset_count", UW'(count), UW'(0));
    chk("reset_valid", UW'(umi_out_valid), UW'(0));

    for (int i = 0; i < 18; i++) begin
      cycle(vecs[i].v, UW'(vecs[i].d), vecs[i].r, vecs[i].c, 1'b0);
      chk($sformatf("vec%0d_count", i), UW'(count), UW'(vecs[i].cnt));
      chk($sformatf("vec%0d_hwm", i), UW'(hwm), UW'(vecs[i].hw));
      chk($sformatf("vec%0d_valid", i), UW'(umi_out_valid), UW'(vecs[i].val));
      if (vecs[i].val) chk($sformatf("vec%0d_pkt", i), umi_out_packet, UW'(vecs[i].pkt));
    end

    // Fill to full; 5th packet held upstream; simultaneous pop does not admit it.
    for (int i = 1; i <= 4; i++) cycle(1'b1, UW'(i), 1'b0, 1'b0, 1'b0);
    chk("full_in_ready", UW'(umi_in_ready), UW'(0));
    cycle(1'b1, UW'(5), 1'b1, 1'b0, 1'b0);
    chk("full_pop_count", UW'(count), UW'(3));
    chk("full_pop_data", last_pop, UW'(1));
    cycle(1'b1, UW'(5), 1'b0, 1'b0, 1'b0);
    chk("fifth_accepted", UW'(count), UW'(4));
    for (int i = 2; i <= 5; i++) begin
      cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
      chk("fill_order", last_pop, UW'(i));
    end

    // Steady stream at count=2 across many pointer wraps.
    cycle(1'b1, UW'(16'h1000), 1'b0, 1'b1, 1'b0);
    cycle(1'b1, UW'(16'h1001), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 100; i++) cycle(1'b1, UW'(16'h1002 + i), 1'b1, 1'b0, 1'b0);
    chk("stream_count", UW'(count), UW'(2));
    chk("stream_hwm", UW'(hwm), UW'(2));
    while (sb.size() > 0) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Random valid/ready traffic with incrementing payloads.
    sent = 0;
    guard = 0;
    pops = 0;
    payload = UW'(32'h5000_0000);
    while (sent < 1000 && guard < 20000) begin
      logic v, r;
      v = 1'($urandom_range(1));
      r = 1'($urandom_range(1));
      if (v && sb.size() < DEPTH) sent++;
      cycle(v, payload, r, 1'b0, 1'b0);
      if (v && umi_in_valid && sb.size() > 0 && sb[sb.size()-1] == payload) payload = payload + 1'b1;
      guard++;
    end
    guard = 0;
    while (sb.size() > 0 && guard < 100) begin
      cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
      guard++;
    end
    chk("random_pushed", UW'(sent), UW'(1000));
    chk("random_popped", UW'(pops), UW'(1000));
    chk("random_last", last_pop, UW'(32'h5000_0000) + UW'(999));
    chk("random_hwm_le_depth", UW'(hwm <= 3'(DEPTH)), UW'(1));

    // Reset mid-stream with three packets buffered.
    for (int i = 0; i < 3; i++) cycle(1'b1, UW'(8'hE0 + i), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, UW'(8'hEE), 1'b1, 1'b0, 1'b1);
    chk("rst_valid", UW'(umi_out_valid), UW'(0));
    chk("rst_in_ready", UW'(umi_in_ready), UW'(0));
    chk("rst_count", UW'(count), UW'(0));
    chk("rst_hwm", UW'(hwm), UW'(0));
    cycle(1'b1, UW'(8'hEF), 1'b1, 1'b0, 1'b1);
    cycle(1'b1, UW'(8'hB0), 1'b0, 1'b0, 1'b0);
    chk("post_rst_valid", UW'(umi_out_valid), UW'(1));
    chk("post_rst_pkt", umi_out_packet, UW'(8'hB0));
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("post_rst_drained", UW'(umi_out_valid), UW'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/umi_pkt_fifo.md
Name: umi_pkt_fifo

Overview:
Elastic UMI packet buffer between a packet source (umi_rx_sim queue reader or umi_gpio outbound port) and a packet sink (ebrick_core umi1_in or umi_tx_sim).
- Decouples backpressure so bursty queue traffic does not stall the DUT cycle-by-cycle.
- Reports its fill level and a clearable high-water mark so benches can check flow-control margins.
- No ready-to-ready combinational path in either direction.

Parameters:
UW, 256, UMI packet width in bits.
DEPTH, 4, number of packet entries; power of two, minimum 2.
AW, $clog2(DEPTH), entry index width; derived, never overridden.

Ports:
clk  input  1  clock; all state on rising edge
rst  input  1  synchronous, active-high reset
umi_in_valid  input  1  upstream packet valid
umi_in_packet  input  UW  upstream packet
umi_in_ready  output  1  FIFO can accept a packet
umi_out_valid  output  1  head packet valid
umi_out_packet  output  UW  head packet
umi_out_ready  input  1  downstream accepts head
count  output  AW+1  current occupancy, 0..DEPTH
hwm  output  AW+1  max occupancy since reset or last clear
hwm_clear  input  1  synchronous clear of hwm

Behaviour:
- Storage: DEPTH x UW register array. Write and read pointers are AW+1 bits and wrap modulo 2*DEPTH.
  - empty = (wr_ptr == rd_ptr).
  - full = index bits equal and MSBs differ.
- Push = umi_in_valid && umi_in_ready. Pop = umi_out_valid && umi_out_ready.
- umi_in_ready = !full && !rst. It is a function of registered state only.
  - It does not depend on umi_out_ready; a full FIFO rejects input even when popping in the same cycle.
- umi_out_valid = !empty. umi_out_packet = mem[rd_ptr[AW-1:0]], first-word-fall-through.
- Latency: a packet pushed in cycle N is presented at the output in cycle N+1. There is no same-cycle bypass when empty.
- Ordering is strict FIFO. No packet is dropped or duplicated.
- Data stability:
  - umi_in_valid may drop without a handshake; nothing is captured.
  - While umi_out_valid=1 and umi_out_ready=0, umi_out_packet and umi_out_valid hold stable.
- count update per cycle:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on push and pop together (legal whenever 0 < count < DEPTH).
- hwm:
  - Next value = max(hwm, next count) each cycle.
  - hwm_clear loads next count, not 0.
  - Clear and push in the same cycle: hwm reflects the post-push count.
- Reset (rst=1 at an edge) takes effect on the next edge:
  - Pointers, count and hwm go to 0.
  - umi_out_valid=0 and umi_in_ready=0 while rst is held.
  - Stored data is not cleared, and umi_out_packet is don't-care while invalid.
  - Reset mid-stream discards all buffered packets. Any push or pop asserted in a reset cycle is ignored.
- Boundary conditions:
  - At empty, umi_out_ready is ignored.
  - At full, umi_in_valid is ignored and the packet is held upstream by protocol.
  - Pointer wrap past 2*DEPTH-1 returns to 0 with no state change.
- Unknown-safe: no X propagates to umi_in_ready, umi_out_valid, count or hwm after reset.

Decomposition:
- Shared package umi_sim_pkg:
  - Constant UMI_UW=256.
  - Packet typedef umi_packet_t (logic [UMI_UW-1:0]).
  - Helper function for the pointer full/empty comparison, reusable by other sim FIFOs.
- One natural sub-module, umi_pkt_fifo_mem: DEPTH x UW register array with one write port and one asynchronous read port.
  - Pointer, flag, count and hwm logic stays in the top.

Test Plan:
- Reset, then 3 pushes (0xA1, 0xA2, 0xA3), out_ready=0 -> count=3, hwm=3, out_packet=0xA1 stable. Then out_ready=1 -> 0xA1, 0xA2, 0xA3 on consecutive cycles, count returns to 0.
- Fill with DEPTH=4 (packets 1..4) -> in_ready=0 from the cycle after the 4th push. 5th packet held upstream. Simultaneous pop does not admit it that cycle; it is accepted the next cycle. Output order is 1, 2, 3, 4, 5.
- Steady stream at 1 push + 1 pop per cycle for 100 cycles with count=2 -> count stays 2, hwm=2, sequence intact across pointer wrap.
- Random valid/ready (50% each), 1000 incrementing-payload packets -> scoreboard matches all 1000 in order, count never exceeds 4, hwm<=4.
- Push 4, pop 3, then hwm_clear -> hwm=1. hwm_clear with simultaneous push -> hwm=2.
- Assert rst with count=3 -> next cycle out_valid=0, in_ready=0, count=0, hwm=0. After rst is released, first new packet 0xB0 appears at the output one cycle after its push, with no stale packets.
